// File: rtl/bfloat_16_pkg.sv
// Shared types and helpers for the bfloat16 vector accumulator.
package bfloat_16_pkg;

  localparam int          BF16_W        = 16;
  localparam logic [15:0] BF16_POS_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    GET_IN,
    SEND_A,
    SEND_B,
    WAIT_Z,
    PUT_OUT
  } acc_state_t;

  // Sign bit ignored: both +0 and -0 count as zero.
  function automatic logic bf16_is_zero(input logic [BF16_W-1:0] v);
    return (v[BF16_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/bfloat_16_accumulator_if.sv
// Element input, adder operand/sum and result channels of the accumulator.
interface bfloat_16_accumulator_if #(
  parameter int CNT_W = 8
);
  import bfloat_16_pkg::*;

  logic [BF16_W-1:0] in_data;
  logic              in_last;
  logic              in_stb;
  logic              in_ack;

  logic [BF16_W-1:0] add_a;
  logic [BF16_W-1:0] add_b;
  logic              add_a_stb;
  logic              add_b_stb;
  logic              add_a_ack;
  logic              add_b_ack;

  logic [BF16_W-1:0] add_z;
  logic              add_z_stb;
  logic              add_z_ack;

  logic [BF16_W-1:0] out_z;
  logic [CNT_W-1:0]  out_count;
  logic              out_stb;
  logic              out_ack;

  // Accumulator side
  modport slave (
    input  in_data, in_last, in_stb, add_a_ack, add_b_ack, add_z, add_z_stb, out_ack,
    output in_ack, add_a, add_b, add_a_stb, add_b_stb, add_z_ack, out_z, out_count, out_stb
  );

  // Environment side: element source, adder and result consumer
  modport master (
    output in_data, in_last, in_stb, add_a_ack, add_b_ack, add_z, add_z_stb, out_ack,
    input  in_ack, add_a, add_b, add_a_stb, add_b_stb, add_z_ack, out_z, out_count, out_stb
  );

endinterface

// File: rtl/bfloat_16_hs_sender.sv
// Initiator-side hold register: data/stb held from load until the ack cycle.
module bfloat_16_hs_sender #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] data,
  output logic         stb,
  input  logic         ack
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stb  <= 1'b0;
      data <= '0;
    end else if (stb && ack) begin
      stb <= 1'b0;
    end else if (load) begin
      data <= load_data;
      stb  <= 1'b1;
    end
  end

endmodule

// File: rtl/bfloat_16_accumulator.sv
// Sums a stream of bfloat16 vectors through an external adder.
// Optional BF16_ACC_ZERO_BYPASS_EN: +/-0 elements skip the adder round trip.
module bfloat_16_accumulator
  import bfloat_16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  bfloat_16_accumulator_if.slave    bus
);

  acc_state_t        state;
  logic [BF16_W-1:0] acc;
  logic [BF16_W-1:0] elem;
  logic              last;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic              in_ack;
  logic              z_ack;

  logic              in_xfer, a_xfer, b_xfer, z_xfer, o_xfer;
  logic              skip;
  logic              a_load, b_load, r_load;
  logic [BF16_W-1:0] a_q, b_q;
  logic              a_stb, b_stb, r_stb;
  logic [BF16_W+CNT_W-1:0] r_ld, r_q;

  always_comb begin
    count_inc = count + CNT_W'(1);
    in_xfer   = (state == GET_IN) && in_ack && bus.in_stb;
    a_xfer    = a_stb && bus.add_a_ack;
    b_xfer    = b_stb && bus.add_b_ack;
    z_xfer    = (state == WAIT_Z) && z_ack && bus.add_z_stb;
    o_xfer    = r_stb && bus.out_ack;
`ifdef BF16_ACC_ZERO_BYPASS_EN
    skip      = bf16_is_zero(bus.in_data);
`else
    skip      = 1'b0;
`endif
    a_load    = in_xfer && !skip;
    b_load    = a_xfer;
    r_load    = (in_xfer && skip && bus.in_last) || (z_xfer && last);
    // A bypassed closing element leaves acc untouched but still counts.
    r_ld      = z_xfer ? {bus.add_z, count} : {acc, count_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      in_ack <= 1'b0;
      z_ack  <= 1'b0;
      last   <= 1'b0;
      acc    <= BF16_POS_ZERO;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc    <= BF16_POS_ZERO;
          count  <= '0;
          in_ack <= 1'b1;
          state  <= GET_IN;
        end
        GET_IN: begin
          if (in_xfer) begin
            elem   <= bus.in_data;
            last   <= bus.in_last;
            count  <= count_inc;
            in_ack <= 1'b0;
            if (!skip)            state <= SEND_A;
            else if (bus.in_last) state <= PUT_OUT;
          end else begin
            in_ack <= 1'b1;
          end
        end
        SEND_A: if (a_xfer) state <= SEND_B;
        SEND_B: begin
          if (b_xfer) begin
            z_ack <= 1'b1;
            state <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (z_xfer) begin
            acc   <= bus.add_z;
            z_ack <= 1'b0;
            if (last) begin
              state <= PUT_OUT;
            end else begin
              in_ack <= 1'b1;
              state  <= GET_IN;
            end
          end
        end
        PUT_OUT: if (o_xfer) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bfloat_16_hs_sender #(.W(BF16_W)) u_send_a (
    .clk(clk), .rst(rst), .load(a_load), .load_data(acc),
    .data(a_q), .stb(a_stb), .ack(bus.add_a_ack)
  );

  bfloat_16_hs_sender #(.W(BF16_W)) u_send_b (
    .clk(clk), .rst(rst), .load(b_load), .load_data(elem),
    .data(b_q), .stb(b_stb), .ack(bus.add_b_ack)
  );

  bfloat_16_hs_sender #(.W(BF16_W + CNT_W)) u_send_out (
    .clk(clk), .rst(rst), .load(r_load), .load_data(r_ld),
    .data(r_q), .stb(r_stb), .ack(bus.out_ack)
  );

  assign bus.in_ack    = in_ack;
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.add_a_stb = a_stb;
  assign bus.add_b_stb = b_stb;
  assign bus.add_z_ack = z_ack;
  assign bus.out_z     = r_q[BF16_W+CNT_W-1:CNT_W];
  assign bus.out_count = r_q[CNT_W-1:0];
  assign bus.out_stb   = r_stb;

endmodule

// File: doc/bfloat_16_accumulator.md
BFLOAT_16_ACCUMULATOR -- requirements
Module: bfloat_16_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the element counter.
REQ-002 SHALL have clk  input  1  clock; all logic is on the rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have in_data  input  16  bfloat16 element.
REQ-005 SHALL have in_last  input  1  element closes the current vector.
REQ-006 SHALL have in_stb  input  1  element valid.
REQ-007 SHALL have in_ack  output  1  block ready for an element.
REQ-008 SHALL have add_a / add_b  output  16 each  adder operands (accumulator / element).
REQ-009 SHALL have add_a_stb, add_b_stb  output  1 each  operand valid.
REQ-010 SHALL have add_a_ack, add_b_ack  input  1 each  adder accepts operand.
REQ-011 SHALL have add_z  input  16  adder sum.
REQ-012 SHALL have add_z_stb  input  1  sum valid.
REQ-013 SHALL have add_z_ack  output  1  block accepts sum.
REQ-014 SHALL have out_z  output  16  final vector sum.
REQ-015 SHALL have out_count  output  CNT_W  elements in the vector (wraps).
REQ-016 SHALL have out_stb  output  1  result valid.
REQ-017 SHALL have out_ack  input  1  consumer accepts result.

Function
REQ-018 SHALL transfer on any stb/ack channel only in a cycle with stb=1 and ack=1; the sender holds data and stb stable until that cycle and drops stb the next cycle.
REQ-019 SHALL act as initiator on add_a/add_b/out, and as responder on in/add_z (registered ack, deasserted the cycle after transfer).
REQ-020 SHALL use states IDLE -> GET_IN -> SEND_A -> SEND_B -> WAIT_Z -> (GET_IN | PUT_OUT) -> IDLE.
REQ-021 IDLE SHALL clear acc to 16'h0000 and count to 0, then go to GET_IN after 1 cycle.
REQ-022 GET_IN SHALL assert in_ack; on transfer it latches in_data and in_last and increments count modulo 2^CNT_W.
REQ-023 SEND_A SHALL present acc with add_a_stb until add_a_ack; SEND_B SHALL then present the element with add_b_stb until add_b_ack.
REQ-024 WAIT_Z SHALL assert add_z_ack; on transfer acc <= add_z, then go to PUT_OUT if the latched last=1, else to GET_IN.
REQ-025 PUT_OUT SHALL drive out_z=acc and out_count=count with out_stb until out_ack; the cycle after transfer it goes to IDLE.
REQ-026 in_ack SHALL be 0 in every state except GET_IN (backpressure while busy or while the result is unaccepted).
REQ-027 Special values (NaN, inf, zero) SHALL pass to the adder unmodified; the block does no arithmetic itself.
REQ-028 A single-element vector SHALL yield out_z = +0 + element, as returned by the adder.

Reset
REQ-029 When rst=1 at a clock edge, the next state SHALL be IDLE, with in_ack, add_a_stb, add_b_stb, add_z_ack and out_stb =0, acc=16'h0000, count=0, out_z=0 and out_count=0; this holds in every state, including mid-handshake.
REQ-030 The adder SHALL share rst, so an in-flight sum is discarded on both sides.

Configuration
REQ-031 With BF16_ACC_ZERO_BYPASS_EN defined, an element with bits[14:0]=0 (±0) SHALL skip SEND_A/SEND_B/WAIT_Z: acc stays unchanged, count still increments, and the next state follows in_last.
REQ-032 Without BF16_ACC_ZERO_BYPASS_EN, every element SHALL make one adder transaction; out_z SHALL be identical in both builds.

Structure
REQ-033 Package bfloat_16_pkg SHALL hold the state enumeration, BF16_W=16, BF16_POS_ZERO=16'h0000 and a zero-detect function.
REQ-034 Sub-module bfloat_16_hs_sender (a data/stb hold register cleared on ack) SHALL be used for the operand channel and for the result channel.

Verification
REQ-035 Vector 3F80, 4000(last) with an adder stub -> out_z=4040, out_count=2, out_stb held until out_ack.
REQ-036 Single 3F80(last) -> out_z=3F80, out_count=1.
REQ-037 Vector 7F80, FF80(last) -> out_z=FFC0 (NaN); the block neither stalls nor drops the result.
REQ-038 Vector 3F80, 8000, 3F80(last) -> out_z=4000, out_count=3; with the macro defined, 2 adder transactions occur, without it 3.
REQ-039 out_ack held low 10 cycles with in_stb=1 -> out_z and out_stb stable, in_ack=0 throughout; the result is accepted on the first out_ack.
REQ-040 rst pulsed in WAIT_Z and in SEND_B -> all stb/ack outputs are 0 the next cycle, and a following vector 4000(last) gives out_z=4000, out_count=1.
